// File: rtl/pencere_besleyici.sv
// pencere_besleyici: raster-order pixel feeder. Keeps two line buffers and a
// 3x3 window, and streams each interior window serially to medyan_birimi.
`ifndef PIXEL_BIT
`define PIXEL_BIT 8
`endif

module pencere_besleyici #(
  parameter int GENISLIK  = 8,
  parameter int YUKSEKLIK = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [`PIXEL_BIT-1:0] piksel_i,
  input  logic                  piksel_gecerli_i,
  output logic                  piksel_hazir_o,
  output logic [`PIXEL_BIT-1:0] sayi_o,
  output logic                  sayi_gecerli_o,
  output logic                  pencere_son_o,
  output logic                  kare_son_o
);
  localparam int PB = `PIXEL_BIT;
  localparam int CW = $clog2(GENISLIK);
  localparam int RW = $clog2(YUKSEKLIK);

  typedef enum logic {BOSTA, YAYIN} state_t;

  state_t                  state;
  logic [3:0]              k;
  logic [CW-1:0]           sutun;
  logic [RW-1:0]           satir;
  logic [PB-1:0]           lb0 [GENISLIK];
  logic [PB-1:0]           lb1 [GENISLIK];
  // [row][col]: row 0 is the oldest line, col 2 the newest column
  logic [2:0][2:0][PB-1:0] win, win_nx;
  logic [8:0][PB-1:0]      samp;
  logic                    kare_win;
  logic                    accept, win_ok, last_pix;
  logic [3:0]              knx;

  assign accept   = rstn_i & piksel_gecerli_i & piksel_hazir_o;
  assign win_ok   = (satir >= RW'(2)) && (sutun >= CW'(2));
  assign last_pix = (satir == RW'(YUKSEKLIK-1)) && (sutun == CW'(GENISLIK-1));
  assign knx      = k + 4'd1;

  always_comb begin
    win_nx = win;
    for (int r = 0; r < 3; r++) begin
      win_nx[r][0] = win[r][1];
      win_nx[r][1] = win[r][2];
    end
    win_nx[0][2] = lb1[sutun];
    win_nx[1][2] = lb0[sutun];
    win_nx[2][2] = piksel_i;
  end

  always_comb begin
    samp = '0;
    for (int i = 0; i < 9; i++) samp[i] = win[i/3][i%3];
  end

  // Line buffers carry no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[sutun] <= lb0[sutun];
      lb0[sutun] <= piksel_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= BOSTA;
      k              <= '0;
      sutun          <= '0;
      satir          <= '0;
      win            <= '0;
      kare_win       <= 1'b0;
      piksel_hazir_o <= 1'b1;
      sayi_o         <= '0;
      sayi_gecerli_o <= 1'b0;
      pencere_son_o  <= 1'b0;
      kare_son_o     <= 1'b0;
    end else begin
      case (state)
        BOSTA: begin
          if (accept) begin
            win <= win_nx;
            if (sutun == CW'(GENISLIK-1)) begin
              sutun <= '0;
              satir <= (satir == RW'(YUKSEKLIK-1)) ? '0 : satir + RW'(1);
            end else begin
              sutun <= sutun + CW'(1);
            end
            if (win_ok) begin
              state          <= YAYIN;
              k              <= '0;
              kare_win       <= last_pix;
              sayi_o         <= win_nx[0][0];
              sayi_gecerli_o <= 1'b1;
              piksel_hazir_o <= 1'b0;
            end
          end
        end
        YAYIN: begin
          if (k == 4'd8) begin
            state          <= BOSTA;
            k              <= '0;
            sayi_o         <= '0;
            sayi_gecerli_o <= 1'b0;
            pencere_son_o  <= 1'b0;
            kare_son_o     <= 1'b0;
            piksel_hazir_o <= 1'b1;
          end else begin
            k             <= knx;
            sayi_o        <= samp[knx];
            pencere_son_o <= (knx == 4'd8);
            kare_son_o    <= (knx == 4'd8) && kare_win;
          end
        end
        default: state <= BOSTA;
      endcase
    end
  end
endmodule

// File: tb/tb_pencere_besleyici.sv
// Bench for pencere_besleyici: scenario table plus reset-mid-window sequence,
// checked against a window model computed directly from frame pixel arrays.
module tb_pencere_besleyici;
  localparam int G = 4, Y = 4;

  logic       clk = 0, rstn = 0;
  logic [7:0] piksel = 0;
  logic       gecerli = 0;
  logic       hazir, sg, pson, kson;
  logic [7:0] sayi;

  pencere_besleyici #(.GENISLIK(G), .YUKSEKLIK(Y)) dut (
    .clk_i(clk), .rstn_i(rstn), .piksel_i(piksel), .piksel_gecerli_i(gecerli),
    .piksel_hazir_o(hazir), .sayi_o(sayi), .sayi_gecerli_o(sg),
    .pencere_son_o(pson), .kare_son_o(kson));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] v; logic ps; logic ks; } smp_t;
  typedef struct { int stall; int rnd; int frames; int exp_win; } scen_t;

  int   checks = 0, failures = 0;
  smp_t expq[$];
  int   log_q[$], med_q[$], acc_cyc[$];
  int   win_buf[9], srt[9];
  int   win_n = 0, low_run = 0, cyc = 0, first_cyc = -1, tmp;
  int   frame_pix[G*Y];
  int   spec_tab[36] = '{1,2,3,5,6,7,9,10,11, 2,3,4,6,7,8,10,11,12,
                         5,6,7,9,10,11,13,14,15, 6,7,8,10,11,12,14,15,16};
  int   spec_med[4] = '{6,7,10,11};
  scen_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: every burst sample must match the head of the model queue
  always @(negedge clk) begin
    if (!rstn) begin
      low_run = 0; win_n = 0;
    end else begin
      if (!hazir) low_run++;
      else if (low_run > 0) begin chk("hazir_low_len", low_run, 9); low_run = 0; end
      if (sg) begin
        chk("hazir_in_burst", hazir, 0);
        if (log_q.size() == 0) first_cyc = cyc;
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_sample actual=%0d required=none", sayi);
        end else begin
          smp_t e;
          e = expq.pop_front();
          chk("sample", sayi, e.v);
          chk("pencere_son", pson, e.ps);
          chk("kare_son", kson, e.ks);
        end
        log_q.push_back(sayi);
        win_buf[win_n] = sayi; win_n++;
        if (win_n == 9) begin
          for (int i = 0; i < 9; i++) srt[i] = win_buf[i];
          for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
              if (srt[j] > srt[j+1]) begin tmp = srt[j]; srt[j] = srt[j+1]; srt[j+1] = tmp; end
          med_q.push_back(srt[4]);
          win_n = 0;
        end
      end else begin
        chk("idle_flags", {pson, kson}, 0);
      end
    end
  end

  // Reference: every interior (r,c) yields its 3x3 neighbourhood row-major.
  task automatic model_frame();
    for (int r = 2; r < Y; r++)
      for (int c = 2; c < G; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            smp_t s;
            s.v  = 8'(frame_pix[(r-2+i)*G + (c-2+j)]);
            s.ps = (i == 2) && (j == 2);
            s.ks = s.ps && (r == Y-1) && (c == G-1);
            expq.push_back(s);
          end
  endtask

  task automatic build_frame(input int rnd, input int off);
    for (int r = 0; r < Y; r++)
      for (int c = 0; c < G; c++)
        frame_pix[r*G+c] = rnd ? int'($urandom_range(255)) : 4*r + c + 1 + off;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int v, input int stall);
    int t;
    while (int'($urandom_range(99)) < stall) begin
      gecerli = 0; piksel = 8'($urandom);
      @(negedge clk);
    end
    piksel = 8'(v); gecerli = 1; t = 0;
    while (!hazir && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=%0d required=<40", t);
    end
    @(posedge clk); #1;
    acc_cyc.push_back(cyc);
    @(negedge clk);
    gecerli = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() > 0 && t < 200) begin @(negedge clk); t++; end
    repeat (12) @(negedge clk);
    chk("drain_left", expq.size(), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_hazir"}, hazir, 1);
    chk({tag, "_sg"}, sg, 0);
    chk({tag, "_sayi"}, sayi, 0);
    chk({tag, "_pson"}, pson, 0);
    chk({tag, "_kson"}, kson, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{stall: 0,  rnd: 0, frames: 1, exp_win: 4};
    tbl[1] = '{stall: 50, rnd: 0, frames: 1, exp_win: 4};
    tbl[2] = '{stall: 0,  rnd: 0, frames: 2, exp_win: 8};
    tbl[3] = '{stall: 40, rnd: 0, frames: 2, exp_win: 8};
    tbl[4] = '{stall: 30, rnd: 1, frames: 2, exp_win: 8};

    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rstn = 1;
    @(negedge clk);

    for (int s = 0; s < 5; s++) begin
      log_q.delete(); med_q.delete(); acc_cyc.delete(); first_cyc = -1;
      for (int f = 0; f < tbl[s].frames; f++) begin
        build_frame(tbl[s].rnd, 100*f);
        model_frame();
        for (int i = 0; i < G*Y; i++) send(frame_pix[i], tbl[s].stall);
      end
      drain();
      chk("windows", med_q.size(), tbl[s].exp_win);
      chk("samples", log_q.size(), tbl[s].exp_win*9);
      if (tbl[s].rnd == 0 && log_q.size() == tbl[s].exp_win*9) begin
        for (int f = 0; f < tbl[s].frames; f++) begin
          for (int i = 0; i < 36; i++) chk("spec_sample", log_q[f*36+i], spec_tab[i] + 100*f);
          for (int w = 0; w < 4; w++) chk("median", med_q[f*4+w], spec_med[w] + 100*f);
        end
      end
      if (s == 0) begin
        chk("b2b_first10", acc_cyc[9] - acc_cyc[0], 9);
        chk("accept_gap_11_12", acc_cyc[11] - acc_cyc[10], 10);
        chk("first_sample_cycle", first_cyc - acc_cyc[10], 0);
      end
    end

    // Reset in the middle of the first window, then a full replay
    log_q.delete(); med_q.delete();
    build_frame(0, 0);
    model_frame();
    for (int i = 0; i < 11; i++) send(frame_pix[i], 0);
    repeat (4) @(negedge clk);
    #1 rstn = 0;
    #1 chk_reset_outs("midrst");
    chk("midrst_k", log_q.size(), 5);
    expq.delete();
    repeat (2) @(negedge clk);
    chk_reset_outs("midrst_hold");
    rstn = 1;
    log_q.delete(); med_q.delete();
    model_frame();
    @(negedge clk);
    for (int i = 0; i < G*Y; i++) send(frame_pix[i], 0);
    drain();
    chk("replay_samples", log_q.size(), 36);
    if (log_q.size() == 36)
      for (int i = 0; i < 36; i++) chk("replay_sample", log_q[i], spec_tab[i]);
    chk("replay_windows", med_q.size(), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
